regfile_operand_fetch: RTL

Operand-fetch stage that sits directly in front of the 2-read/1-write register file. It accepts issue requests (rs1, rs2, tag) on a valid/ready handshake and drives the file's two read ports. It captures the 1-cycle-latency read data and forwards write-port data the file would otherwise miss. Complete operand pairs are presented downstream on a valid/ready handshake, one request per cycle at full throughput.

---
 rtl/regfile_pkg.sv | 25 ++
 rtl/regfile_operand_fetch_slot.sv | 64 ++++++
 rtl/regfile_operand_fetch.sv | 92 +++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Constants shared with the 2R/1W register file and the operand-fetch stage-B record.
package regfile_pkg;

  localparam int RF_WIDTH      = 32;
  localparam int RF_DEPTH      = 32;
  localparam int RF_ADDR_WIDTH = $clog2(RF_DEPTH);
  localparam int RF_TAG_W      = 8;

  // One operand's share of a held request.
  typedef struct packed {
    logic                     use_op;
    logic [RF_ADDR_WIDTH-1:0] rs;
    logic                     fwd;
    logic [RF_WIDTH-1:0]      fwd_data;
  } opfetch_operand_t;

  // Stage-B request record as seen by downstream.
  typedef struct packed {
    logic                valid;
    logic [RF_TAG_W-1:0] tag;
    opfetch_operand_t    op1;
    opfetch_operand_t    op2;
  } opfetch_req_t;

endpackage

// File: rtl/regfile_operand_fetch_slot.sv
// One operand of the fetch stage: read issue, accept/stall-time write forwarding, operand mux.
// Honours OPFETCH_ZERO_REG_EN (register 0 hardwired to zero).
module opfetch_operand_slot
  import regfile_pkg::*;
#(
  parameter int WIDTH      = RF_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  accept,
  input  logic                  stall,
  input  logic [ADDR_WIDTH-1:0] in_rs,
  input  logic                  in_use,
  input  logic                  wb_en,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [WIDTH-1:0]      wb_data,
  input  logic [WIDTH-1:0]      rf_read_data,
  output logic                  rf_read_en,
  output logic [ADDR_WIDTH-1:0] rf_read_addr,
  output logic [WIDTH-1:0]      op
);

  logic                  use_q;
  logic [ADDR_WIDTH-1:0] rs_q;
  logic                  fwd_q;
  logic [WIDTH-1:0]      fwd_data_q;
  logic                  use_eff;
  logic                  hit_accept;
  logic                  hit_stall;

  // A hardwired-zero index is treated as an unused operand, so it never reads or forwards.
`ifdef OPFETCH_ZERO_REG_EN
  assign use_eff = in_use && (in_rs != '0);
`else
  assign use_eff = in_use;
`endif

  assign rf_read_en   = accept && use_eff;
  assign rf_read_addr = in_rs;

  assign hit_accept = wb_en && (wb_addr == in_rs) && use_eff;
  assign hit_stall  = wb_en && (wb_addr == rs_q) && use_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      use_q      <= 1'b0;
      rs_q       <= '0;
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
    end else if (accept) begin
      use_q <= use_eff;
      rs_q  <= in_rs;
      fwd_q <= hit_accept;
      if (hit_accept) fwd_data_q <= wb_data;
    end else if (stall && hit_stall) begin
      fwd_q      <= 1'b1;
      fwd_data_q <= wb_data;
    end
  end

  assign op = !use_q ? '0 : (fwd_q ? fwd_data_q : rf_read_data);

endmodule

// File: rtl/regfile_operand_fetch.sv
// Operand-fetch stage in front of the 2R/1W register file, one request per cycle, 1-cycle latency.
// Optional build macro: OPFETCH_ZERO_REG_EN (register 0 reads as zero).
module regfile_operand_fetch
  import regfile_pkg::*;
#(
  parameter int WIDTH      = RF_WIDTH,
  parameter int DEPTH      = RF_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int TAG_W      = RF_TAG_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_rs1,
  input  logic [ADDR_WIDTH-1:0] in_rs2,
  input  logic                  in_use1,
  input  logic                  in_use2,
  input  logic [TAG_W-1:0]      in_tag,
  input  logic                  wb_en,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [WIDTH-1:0]      wb_data,
  output logic                  rf_read_en1,
  output logic                  rf_read_en2,
  output logic [ADDR_WIDTH-1:0] rf_read_addr1,
  output logic [ADDR_WIDTH-1:0] rf_read_addr2,
  input  logic [WIDTH-1:0]      rf_read_data1,
  input  logic [WIDTH-1:0]      rf_read_data2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_op1,
  output logic [WIDTH-1:0]      out_op2,
  output logic [TAG_W-1:0]      out_tag
);

  logic             accept;
  logic             stall;
  logic             valid_q;
  logic [TAG_W-1:0] tag_q;

  assign in_ready = rst_n && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign stall    = valid_q && !out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
    end else if (accept) begin
      valid_q <= 1'b1;
      tag_q   <= in_tag;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid = valid_q;
  assign out_tag   = tag_q;

  opfetch_operand_slot #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_slot1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .accept       (accept),
    .stall        (stall),
    .in_rs        (in_rs1),
    .in_use       (in_use1),
    .wb_en        (wb_en),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .rf_read_data (rf_read_data1),
    .rf_read_en   (rf_read_en1),
    .rf_read_addr (rf_read_addr1),
    .op           (out_op1)
  );

  opfetch_operand_slot #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_slot2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .accept       (accept),
    .stall        (stall),
    .in_rs        (in_rs2),
    .in_use       (in_use2),
    .wb_en        (wb_en),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .rf_read_data (rf_read_data2),
    .rf_read_en   (rf_read_en2),
    .rf_read_addr (rf_read_addr2),
    .op           (out_op2)
  );

endmodule
